cf_gpio_in_debounce: RTL and testbench
======================================

Name: cf_gpio_in_debounce

Overview:
- Conditions the raw digital pad input (the per-pad `io_in` from the GPIO pad-configuration wrapper, valid in INPUT/INPUT_PD/INPUT_PU/BIDIR modes) for use by synchronous user logic.
- Function: metastability synchroniser, programmable-length debounce filter, one-cycle rise/fall edge pulses, and a sticky, maskable interrupt flag.
- One instance per GPIO, directly downstream of the pad-config wrapper.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal ≥2).
- CNT_W, 16, width of the debounce counter and the threshold input.
- RESET_LEVEL, 1'b0, reset value of the synchroniser chain and of `level`.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pad_in  input  1  asynchronous pad data; connect to the wrapper's io_in.
- en  input  1  filter enable; 0 freezes `level` and suppresses edges.
- debounce_cycles  input  CNT_W  stability threshold in clk cycles; quasi-static.
- irq_rise_en  input  1  allow a rising edge to set `irq`.
- irq_fall_en  input  1  allow a falling edge to set `irq`.
- irq_clr  input  1  one-cycle clear of `irq`.
- level  output  1  debounced, synchronised pad level.
- rise_pulse  output  1  one-cycle pulse on `level` 0→1.
- fall_pulse  output  1  one-cycle pulse on `level` 1→0.
- irq  output  1  sticky interrupt flag.

Behaviour:
- Reset (rst=1 at a clk edge): sync chain = RESET_LEVEL, level = RESET_LEVEL, cnt = 0, rise_pulse = fall_pulse = 0, irq = 0.
- A reset asserted mid-count or mid-pulse discards all state; no edge is generated by reset.
- Synchroniser: SYNC_STAGES-flop shift chain, running regardless of en. `s` denotes the last stage.
- Counter, when en=1:
  - If s == level: cnt ← 0.
  - If s != level and cnt < debounce_cycles: cnt ← cnt + 1.
  - If s != level and cnt >= debounce_cycles: level ← s, cnt ← 0, and the matching edge pulse is asserted in the same cycle `level` first shows the new value.
- Counter, when en=0: cnt ← 0, level held, pulses 0. Re-enabling starts a fresh count; there is no catch-up edge.
- Comparison is ≥, so lowering debounce_cycles below the current cnt commits on the next cycle. cnt never wraps.
- debounce_cycles = 0: level follows s with one cycle of delay.
- Latency: a clean pad step to the `level` change takes SYNC_STAGES + debounce_cycles + 1 clk cycles.
- Glitch rejection: any return of s to level before the threshold clears cnt.
- Pulses are registered, exactly one cycle long, mutually exclusive, and never back-to-back faster than debounce_cycles + 1 cycles.
- irq:
  - Set when (rise_pulse & irq_rise_en) | (fall_pulse & irq_fall_en).
  - Cleared by irq_clr.
  - If set and clear occur in the same cycle, set wins.
  - Enables are not retroactive: enabling after an edge does not raise irq.
- All outputs registered; no combinational path from any input to any output.

Decomposition:
- Shared package cf_gpio_pkg holds:
  - the GPIO mode encodings (ANALOG=0, INPUT=1, INPUT_PD=2, INPUT_PU=3, OUTPUT=4, BIDIR=5);
  - default constants CF_GPIO_SYNC_STAGES=2 and CF_GPIO_DBNC_W=16.
- One sub-module: cf_sync_ff.
  - Parameterised N-stage, 1-bit synchroniser with synchronous active-high reset value.
  - Reused by other CF blocks.

Test Plan:
1. Reset and glitch rejection. Reset with RESET_LEVEL=0, debounce_cycles=4, en=1; then pad_in=1 for 3 cycles and back to 0. Required: level stays 0, no pulses, irq=0.
2. Clean rising step. pad_in 0→1 held, debounce_cycles=4. Required: level=1 and rise_pulse=1 exactly 7 cycles after the step (2+4+1), pulse lasts 1 cycle, irq=1 with irq_rise_en=1.
3. Zero threshold and falling edge. debounce_cycles=0, pad_in 1→0. Required: fall_pulse at cycle 3 after the step; with irq_fall_en=0, irq is unchanged.
4. irq set/clear collision. Assert irq_clr in the same cycle as rise_pulse with irq_rise_en=1. Required: irq=1 afterwards. A following lone irq_clr gives irq=0.
5. Enable gating. en=0, then pad_in toggles and holds for 20 cycles. Required: level frozen, no pulses. Then set en=1 with debounce_cycles=4. Required: level updates 5 cycles later with one pulse.
6. Mid-operation events.
   - Reset asserted with cnt=3 of 4: level returns to RESET_LEVEL and no pulse is generated.
   - Lowering debounce_cycles from 10 to 2 while cnt=5: commit on the next cycle.

Source files
------------

// File: rtl/cf_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cf_gpio_pkg
// Description : Shared definitions for the CF GPIO blocks.
//               - GPIO pad mode encodings.
//               - Default sizing constants for the input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package cf_gpio_pkg;

    typedef enum logic [2:0] {
        GPIO_MODE_ANALOG   = 3'd0,
        GPIO_MODE_INPUT    = 3'd1,
        GPIO_MODE_INPUT_PD = 3'd2,
        GPIO_MODE_INPUT_PU = 3'd3,
        GPIO_MODE_OUTPUT   = 3'd4,
        GPIO_MODE_BIDIR    = 3'd5
    } gpio_mode_t;

    localparam int CF_GPIO_SYNC_STAGES = 2;
    localparam int CF_GPIO_DBNC_W      = 16;

endpackage : cf_gpio_pkg
`default_nettype wire

// File: rtl/cf_sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : cf_sync_ff
// Description : N-stage, 1-bit flop-chain synchroniser for asynchronous
//               inputs. Synchronous active-high reset loads RESET_VAL into
//               every stage.
// Ports       : clk  - destination clock
//               rst  - synchronous active-high reset
//               i_d  - asynchronous input
//               o_q  - synchronised output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module cf_sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule : cf_sync_ff
`default_nettype wire

// File: rtl/cf_gpio_in_debounce.sv
`default_nettype none
// ============================================================================
// Module      : cf_gpio_in_debounce
// Description : Conditions a raw GPIO pad input for synchronous logic:
//               synchroniser, programmable debounce filter, one-cycle
//               rise/fall pulses and a sticky maskable interrupt flag.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               pad_in            - asynchronous pad data
//               en                - filter enable (0 freezes level)
//               debounce_cycles   - stability threshold in clk cycles
//               irq_rise_en/_fall_en - edge-to-irq enables
//               irq_clr           - one-cycle irq clear
//               level             - debounced level
//               rise_pulse/fall_pulse - one-cycle edge pulses
//               irq               - sticky interrupt flag
// Revision    : 1.0 - initial release
// ============================================================================
module cf_gpio_in_debounce
    import cf_gpio_pkg::*;
#(
    parameter int   SYNC_STAGES = CF_GPIO_SYNC_STAGES,
    parameter int   CNT_W       = CF_GPIO_DBNC_W,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_in,
    input  logic             en,
    input  logic [CNT_W-1:0] debounce_cycles,
    input  logic             irq_rise_en,
    input  logic             irq_fall_en,
    input  logic             irq_clr,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             irq
);

    logic             w_sync;
    logic             w_irq_set;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             r_irq;

    cf_sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pad_in),
        .o_q (w_sync)
    );

    // Pulses are registered, so irq sets on the cycle after the pulse is
    // visible; this keeps irq_clr in the pulse cycle losing to the set.
    assign w_irq_set = (r_rise & irq_rise_en) | (r_fall & irq_fall_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= RESET_LEVEL;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;

            if (!en || (w_sync == r_level)) begin
                r_cnt <= '0;
            end else if (r_cnt < debounce_cycles) begin
                // Strictly below the threshold, so the increment cannot wrap.
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_level <= w_sync;
                r_cnt   <= '0;
                r_rise  <= w_sync;
                r_fall  <= ~w_sync;
            end

            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign irq        = r_irq;

endmodule : cf_gpio_in_debounce
`default_nettype wire

// File: tb/tb_cf_gpio_in_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_cf_gpio_in_debounce
// Description : Self-checking bench for cf_gpio_in_debounce. A cycle model
//               pushes expected {level,rise,fall,irq} each clock into a
//               queue; the negedge checker pops and compares. Directed
//               latency / boundary checks share the same check task.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cf_gpio_in_debounce;

    localparam int   c_SYNC  = 2;
    localparam int   c_CNT_W = 16;
    localparam logic c_RLVL  = 1'b0;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pad_in = 1'b0;
    logic               en = 1'b1;
    logic [c_CNT_W-1:0] debounce_cycles = 16'd4;
    logic               irq_rise_en = 1'b1;
    logic               irq_fall_en = 1'b0;
    logic               irq_clr = 1'b0;
    logic               level, rise_pulse, fall_pulse, irq;

    int n_cmp = 0;
    int n_err = 0;
    int n_rise = 0;
    int n_fall = 0;

    cf_gpio_in_debounce #(
        .SYNC_STAGES (c_SYNC),
        .CNT_W       (c_CNT_W),
        .RESET_LEVEL (c_RLVL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pad_in          (pad_in),
        .en              (en),
        .debounce_cycles (debounce_cycles),
        .irq_rise_en     (irq_rise_en),
        .irq_fall_en     (irq_fall_en),
        .irq_clr         (irq_clr),
        .level           (level),
        .rise_pulse      (rise_pulse),
        .fall_pulse      (fall_pulse),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [3:0] sb_q[$];
    logic       m_sync [c_SYNC];
    logic       m_level, m_rise, m_fall, m_irq;
    int         m_cnt;

    always @(posedge clk) begin
        logic s;
        if (rst) begin
            for (int i = 0; i < c_SYNC; i++) m_sync[i] = c_RLVL;
            m_level = c_RLVL; m_cnt = 0; m_rise = 0; m_fall = 0; m_irq = 0;
        end else begin
            if ((m_rise && irq_rise_en) || (m_fall && irq_fall_en)) m_irq = 1;
            else if (irq_clr) m_irq = 0;
            s = m_sync[c_SYNC-1];
            m_rise = 0; m_fall = 0;
            if (en && (s != m_level)) begin
                if (m_cnt >= int'(debounce_cycles)) begin
                    m_level = s; m_cnt = 0;
                    if (s) m_rise = 1; else m_fall = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_cnt = 0;
            end
            for (int i = c_SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = pad_in;
        end
        sb_q.push_back({m_level, m_rise, m_fall, m_irq});
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("model", {28'd0, level, rise_pulse, fall_pulse, irq}, {28'd0, e});
        end
        if (rise_pulse === 1'b1) n_rise++;
        if (fall_pulse === 1'b1) n_fall++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Counts posedges until the selected pulse appears; -1 on timeout.
    task automatic wait_pulse(input bit rise, input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            edge1();
            if ((rise ? rise_pulse : fall_pulse) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;
    int nr0, nf0;

    initial begin
        // 1. reset and glitch rejection
        cyc(3);
        rst = 1'b0;
        cyc(2);
        check_val("rst_level", {31'd0, level}, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        pad_in = 1'b1; cyc(3);
        pad_in = 1'b0; cyc(10);
        check_val("glitch_level", {31'd0, level}, 32'd0);
        check_val("glitch_pulses", n_rise + n_fall, 32'd0);
        check_val("glitch_irq", {31'd0, irq}, 32'd0);

        // 2. clean rising step: 2 sync + 4 + 1
        pad_in = 1'b1;
        wait_pulse(1'b1, 40, lat);
        check_val("rise_latency", lat, 32'd7);
        check_val("rise_level", {31'd0, level}, 32'd1);
        edge1();
        check_val("rise_one_cycle", {31'd0, rise_pulse}, 32'd0);
        check_val("rise_irq", {31'd0, irq}, 32'd1);
        cyc(5);

        // 3. zero threshold, falling edge, fall irq disabled
        debounce_cycles = 16'd0;
        pad_in = 1'b0;
        wait_pulse(1'b0, 40, lat);
        check_val("fall_latency_d0", lat, 32'd3);
        edge1();
        check_val("fall_irq_unchanged", {31'd0, irq}, 32'd1);
        cyc(3);

        // 4. set/clear collision
        irq_clr = 1'b1; cyc(1); irq_clr = 1'b0; cyc(1);
        check_val("clr_irq", {31'd0, irq}, 32'd0);
        pad_in = 1'b1;
        wait_pulse(1'b1, 40, lat);
        check_val("rise_latency_d0", lat, 32'd3);
        irq_clr = 1'b1;
        edge1();
        irq_clr = 1'b0;
        check_val("collision_set_wins", {31'd0, irq}, 32'd1);
        edge1();
        irq_clr = 1'b1;
        edge1();
        irq_clr = 1'b0;
        check_val("lone_clr", {31'd0, irq}, 32'd0);
        cyc(3);

        // 5. enable gating
        nr0 = n_rise; nf0 = n_fall;
        en = 1'b0;
        debounce_cycles = 16'd4;
        pad_in = 1'b0; cyc(20);
        check_val("en0_level", {31'd0, level}, 32'd1);
        check_val("en0_pulses", (n_rise - nr0) + (n_fall - nf0), 32'd0);
        en = 1'b1;
        wait_pulse(1'b0, 40, lat);
        check_val("reenable_latency", lat, 32'd5);
        check_val("reenable_level", {31'd0, level}, 32'd0);
        cyc(5);

        // 6a. reset mid-count (cnt=3 of 4)
        nr0 = n_rise;
        pad_in = 1'b1;
        repeat (5) edge1();
        rst = 1'b1; pad_in = 1'b0;
        edge1();
        check_val("midrst_level", {31'd0, level}, {31'd0, c_RLVL});
        rst = 1'b0;
        cyc(12);
        check_val("midrst_no_pulse", n_rise - nr0, 32'd0);

        // 6b. lower threshold below current count
        debounce_cycles = 16'd10;
        pad_in = 1'b1;
        repeat (7) edge1();
        check_val("pre_lower_level", {31'd0, level}, 32'd0);
        debounce_cycles = 16'd2;
        edge1();
        check_val("lower_commit_level", {31'd0, level}, 32'd1);
        check_val("lower_commit_pulse", {31'd0, rise_pulse}, 32'd1);
        cyc(4);

        // random phase, checked by the model
        irq_fall_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) pad_in = ~pad_in;
            if ($urandom_range(0, 30) == 0) debounce_cycles = 16'($urandom_range(0, 3));
            en          = ($urandom_range(0, 9) != 0);
            irq_clr     = ($urandom_range(0, 7) == 0);
            irq_rise_en = ($urandom_range(0, 3) != 0);
            irq_fall_en = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 150) == 0);
            cyc(1);
        end
        rst = 1'b0; irq_clr = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cf_gpio_in_debounce
`default_nettype wire
